// File: rtl/ssd_scan_if.sv
// ssd_scan_if
// Groups the receive-side inputs and the display-side outputs of the
// seven-segment scan controller.
//   rx_data    [7:0]  received UART byte
//   rx_valid          one-clock strobe, rx_data valid this cycle
//   clr               one-clock strobe, empties the display buffer
//   dig_sel    [3:0]  active-low one-hot digit enable, 4'b1111 = all off
//   nibble     [3:0]  hex value for the selected digit
//   dash              1 = show a dash instead of nibble
//   frame_tick        one-clock pulse after the digit-3 slot ends
// Modport slave is the controller; modport master is whoever feeds it
// bytes and consumes the display signals.
interface ssd_scan_if;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       clr;
   logic [3:0] dig_sel;
   logic [3:0] nibble;
   logic       dash;
   logic       frame_tick;

   modport master (
      output rx_data, rx_valid, clr,
      input  dig_sel, nibble, dash, frame_tick
   );

   modport slave (
      input  rx_data, rx_valid, clr,
      output dig_sel, nibble, dash, frame_tick
   );
endinterface

// File: rtl/ssd_scan_controller.sv
// ssd_scan_controller
// Captures received bytes into a 2-byte display buffer and time-multiplexes
// four seven-segment digits, with a blanking interval at the start of every
// slot to avoid ghosting. Digits that have no received data show a dash.
// Ports:
//   clk   system clock
//   rst   synchronous, active-high reset
//   bus   ssd_scan_if.slave: rx_data/rx_valid/clr in, dig_sel/nibble/
//         dash/frame_tick out (all outputs registered)
// Parameters:
//   SCAN_DIV      clocks per digit slot (>= 2)
//   BLANK_CYCLES  clocks of all-off at the start of each slot (< SCAN_DIV)
//   IDLE_TIMEOUT  clocks without a byte before reverting to dashes (0 = off)
module ssd_scan_controller #(
   parameter int SCAN_DIV     = 416_667,
   parameter int BLANK_CYCLES = 2_500,
   parameter int IDLE_TIMEOUT = 0
) (
   input  logic     clk,
   input  logic     rst,
   ssd_scan_if.slave bus
);

   localparam int PW = $clog2(SCAN_DIV);
   localparam int IW = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;

   localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
   localparam logic [PW-1:0] BLANK_END  = PW'(BLANK_CYCLES);
   localparam logic [IW-1:0] IDLE_MAX   = IW'(IDLE_TIMEOUT);
   localparam logic [IW-1:0] IDLE_LAST  = IW'((IDLE_TIMEOUT > 0) ? IDLE_TIMEOUT - 1 : 0);

   logic [15:0]   buffer;
   logic [1:0]    count;       // bytes held, saturates at 2
   logic [PW-1:0] presc;
   logic [1:0]    idx;
   logic [IW-1:0] idle_cnt;

   logic [3:0]    dig_sel_q;
   logic [3:0]    nibble_q;
   logic          dash_q;
   logic          frame_tick_q;

   logic [3:0]    sel_nib;
   logic          sel_ok;
   logic [3:0]    sel_onehot;

   // Value and validity of the digit the scan is currently on. Digits 0-1
   // need one byte, digits 2-3 need both bytes.
   always_comb begin
      sel_nib = 4'h0;
      sel_ok  = 1'b0;
      case (idx)
         2'd0: begin sel_nib = buffer[3:0];   sel_ok = (count != 2'd0); end
         2'd1: begin sel_nib = buffer[7:4];   sel_ok = (count != 2'd0); end
         2'd2: begin sel_nib = buffer[11:8];  sel_ok = (count == 2'd2); end
         default: begin sel_nib = buffer[15:12]; sel_ok = (count == 2'd2); end
      endcase
      sel_onehot = ~(4'b0001 << idx);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         buffer       <= 16'h0000;
         count        <= 2'd0;
         presc        <= '0;
         idx          <= 2'd0;
         idle_cnt     <= '0;
         dig_sel_q    <= 4'b1111;
         nibble_q     <= 4'h0;
         dash_q       <= 1'b1;
         frame_tick_q <= 1'b0;
      end else begin
         // Free-running scan; nothing on the receive side touches its phase.
         if (presc == PRESC_LAST) begin
            presc        <= '0;
            idx          <= idx + 2'd1;
            frame_tick_q <= (idx == 2'd3);
         end else begin
            presc        <= presc + PW'(1);
            frame_tick_q <= 1'b0;
         end

         // All three display outputs come from the same pre-edge state so
         // they never disagree with each other.
         dig_sel_q <= (presc < BLANK_END) ? 4'b1111 : sel_onehot;
         nibble_q  <= sel_ok ? sel_nib : 4'h0;
         dash_q    <= ~sel_ok;

         // clr beats a simultaneous byte; a byte beats the idle timeout.
         if (bus.clr) begin
            buffer <= 16'h0000;
            count  <= 2'd0;
         end else if (bus.rx_valid) begin
            buffer <= {buffer[7:0], bus.rx_data};
            if (count != 2'd2)
               count <= count + 2'd1;
         end else if ((IDLE_TIMEOUT != 0) && (idle_cnt >= IDLE_LAST)) begin
            // Buffer is kept; only the count is dropped so digits show dashes.
            count <= 2'd0;
         end

         if (IDLE_TIMEOUT != 0) begin
            if (bus.rx_valid)
               idle_cnt <= '0;
            else if (idle_cnt != IDLE_MAX)
               idle_cnt <= idle_cnt + IW'(1);
         end
      end
   end

   assign bus.dig_sel    = dig_sel_q;
   assign bus.nibble     = nibble_q;
   assign bus.dash       = dash_q;
   assign bus.frame_tick = frame_tick_q;

endmodule
